instr_encoder: RTL
==================

# instr_encoder

Instruction encoder and instruction-memory loader for the single-cycle MIPS core. Accepts abstract operations (operation enum plus register/immediate fields), encodes each into a 32-bit MIPS instruction word, buffers it in a small FIFO, and writes words sequentially into instruction memory from a base address. It is the producer of the opcode/funct fields consumed by the core's control decoder and is used to load programs and generate test streams.

## Interface
- DEPTH, 4: encoded-word FIFO depth (power of two, ≥2)
- IMEM_AW, 6: instruction memory word-address width
- BASE_ADDR, 0: first word address written after `start`

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a load at BASE_ADDR
- finish  in  1  pulse: no more instructions; drain and complete
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts this cycle
- in_op  in  5  operation, enum `enc_op_t`
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  immediate
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  IMEM_AW  write address
- imem_wdata  out  32  encoded instruction word
- word_count  out  IMEM_AW+1  words written since `start`
- done  out  1  load complete
- err  out  1  sticky: illegal `in_op` seen
- checksum  out  32  XOR of written words (see Configuration)

## Operation
- Encoding, R-type `{6'b0, rs, rt, rd, shamt, funct}`: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 (shamt field forced 0); SLL 000000, SRL 000010, SRA 000011 (rs field forced 0). NOP encodes 32'h0.
- I-type `{opcode, rs, rt, imm}`: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011.
- Illegal enum value: accepted (handshake completes), not pushed, not counted; `err` set until reset/`start`.
- FSM states:
  - IDLE: `start` → LOAD.
  - LOAD: accepts instructions. `finish` → DRAIN; an accept in the same cycle as `finish` is still taken. Accepted count reaching capacity (2^IMEM_AW − BASE_ADDR) → DRAIN.
  - DRAIN: no accepts. FIFO empty after the cycle's write → DONE.
  - DONE: `start` → LOAD.
- `start` while in LOAD or DRAIN is ignored. `start` in IDLE/DONE clears `word_count`, `err`, `checksum`, and FIFO, and sets the address to BASE_ADDR.
- `in_ready` = (state==LOAD) && FIFO not full && accepted count < capacity. When full, there is no pass-through even if a pop occurs in the same cycle.
- Write port: when the FIFO is non-empty, pop one word per cycle, assert `imem_we` for that cycle, then increment address and `word_count`. Address never wraps; capacity limits accepts.

## Timing
- Reset values: state IDLE, FIFO empty, `in_ready`=0, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `word_count`=0, `done`=0, `err`=0, `checksum`=0.
- Encoding is combinational into the FIFO push. `imem_we`/`imem_addr`/`imem_wdata` are registered outputs.
- Latency: accept at cycle N with FIFO empty → `imem_we` at N+1. Sustained throughput is 1 word/cycle.
- `done` rises the cycle after the final write. It stays high until `start` or `reset`.
- Reset mid-load aborts immediately. Words already written to memory remain there; nothing else is written.

## Configuration
- `ENC_CHECKSUM_EN` defined: `checksum` updates as `checksum ^= imem_wdata` on every `imem_we` cycle and is cleared on `start`/`reset`.
- Not defined: `checksum` is tied to 0 and no checksum register exists.

## Structure
- Package `enc_pkg`: `enc_op_t` enum (NOP=0, ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA, ADDI, ANDI, ORI, XORI, LW, SW), opcode and funct localparams, state enum.
- One sub-module, `enc_fifo` (parameterised DEPTH×32, push/pop/full/empty), plus a combinational encode function in the package.

## Test plan
- Basic R-type: `start`, then ADD rs=1 rt=2 rd=3, then `finish` → single write addr 0 data 0x00221820 one cycle after accept; `done` next cycle; `word_count`=1.
- I-type and shift stream: ADDI rs=1 rt=2 imm=5, SLL rt=2 rd=4 shamt=3 with in_rs=7, SW rs=1 rt=2 imm=8 → addrs 0,1,2 with data 0x20220005, 0x000220C0, 0xAC220008.
- Backpressure: hold `in_valid` 10 cycles with DEPTH=4 → no word lost or duplicated; `word_count`=10; addresses 0–9 contiguous.
- Capacity: IMEM_AW=2, BASE_ADDR=1, feed 5 instructions → only 3 accepted; `in_ready` low afterwards; `done` without `finish`.
- Illegal op: in_op=31 between two ADDs → `err`=1, 2 writes; `start` clears `err`.
- With `ENC_CHECKSUM_EN`: ADD and ADDI from the scenarios above → `checksum`=0x20001825. Assert `reset` mid-DRAIN → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types for the instruction encoder: operation/state enums, MIPS field
// constants and the combinational operation-to-instruction-word encoder.
package enc_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_NOR  = 5'd6,
    OP_SLT  = 5'd7,
    OP_SLL  = 5'd8,
    OP_SRL  = 5'd9,
    OP_SRA  = 5'd10,
    OP_ADDI = 5'd11,
    OP_ANDI = 5'd12,
    OP_ORI  = 5'd13,
    OP_XORI = 5'd14,
    OP_LW   = 5'd15,
    OP_SW   = 5'd16
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } enc_state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_res_t;

  function automatic enc_res_t enc_encode(input logic [4:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  rd,
                                          input logic [4:0]  shamt,
                                          input logic [15:0] imm);
    enc_res_t res;
    res.legal = 1'b1;
    res.word  = '0;
    case (op)
      OP_NOP:  res.word = '0;
      OP_ADD:  res.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      OP_SUB:  res.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      OP_AND:  res.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      OP_OR:   res.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      OP_XOR:  res.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_XOR};
      OP_NOR:  res.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
      OP_SLT:  res.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      OP_SLL:  res.word = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      OP_SRL:  res.word = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      OP_SRA:  res.word = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRA};
      OP_ADDI: res.word = {OPC_ADDI, rs, rt, imm};
      OP_ANDI: res.word = {OPC_ANDI, rs, rt, imm};
      OP_ORI:  res.word = {OPC_ORI, rs, rt, imm};
      OP_XORI: res.word = {OPC_XORI, rs, rt, imm};
      OP_LW:   res.word = {OPC_LW, rs, rt, imm};
      OP_SW:   res.word = {OPC_SW, rs, rt, imm};
      default: res.legal = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO buffering encoded words between the encoder and the
// instruction-memory write port; i_clr empties it without a full reset.
module enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (i_reset || i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd];
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/instr_encoder.sv
// Encodes abstract operations into MIPS words and streams them into instruction
// memory from BASE_ADDR. Define ENC_CHECKSUM_EN to build the XOR checksum register.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IMEM_AW   = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               finish,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_op,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_shamt,
  input  logic [15:0]        in_imm,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [IMEM_AW:0]   word_count,
  output logic               done,
  output logic               err,
  output logic [31:0]        checksum
);
  localparam logic [IMEM_AW:0]   CAP  = (IMEM_AW+1)'((2**IMEM_AW) - BASE_ADDR);
  localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);

  enc_state_t         r_state;
  logic [IMEM_AW:0]   r_acc;
  logic [IMEM_AW-1:0] r_ptr;
  logic               r_we;
  logic [IMEM_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [IMEM_AW:0]   r_cnt;
  logic               r_done;
  logic               r_err;

  enc_res_t           w_enc;
  logic               w_ready;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_clr;
  logic               w_full;
  logic               w_empty;
  logic [31:0]        w_dout;
  logic [IMEM_AW:0]   w_acc_next;

  assign w_enc      = enc_encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm);
  assign w_ready    = (r_state == ST_LOAD) && !w_full && (r_acc < CAP);
  assign w_accept   = in_valid && w_ready;
  assign w_push     = w_accept && w_enc.legal;
  assign w_pop      = !w_empty && ((r_state == ST_LOAD) || (r_state == ST_DRAIN));
  assign w_clr      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_acc_next = r_acc + (IMEM_AW+1)'(w_push);

  enc_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .i_reset (reset),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_din   (w_enc.word),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // imem_addr shows the address of the word on the bus; r_ptr is the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_ptr   <= BASE;
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_addr  <= r_ptr;
        r_wdata <= w_dout;
        r_ptr   <= r_ptr + 1'b1;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_accept && !w_enc.legal) r_err <= 1'b1;
      r_acc <= w_acc_next;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_acc   <= '0;
            r_ptr   <= BASE;
            r_addr  <= BASE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (finish || (w_acc_next == CAP)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset || w_clr) r_checksum <= '0;
    else if (w_pop)     r_checksum <= r_checksum ^ w_dout;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready   = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_cnt;
  assign done       = r_done;
  assign err        = r_err;
endmodule
